// File: rtl/quad_step_decoder.sv
// Quadrature front end: 2-flop synchronizer, optional debounce (QUAD_STEP_DEBOUNCE_EN),
// Gray-sequence decoder with detent accumulator driving step/ud/err.
module quad_step_decoder #(
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  output logic step,
  output logic ud,
  output logic err
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic signed [3:0] ACC_MAX = 4'(STEPS_PER_DETENT - 1);
  localparam logic signed [3:0] ACC_MIN = -ACC_MAX;

  // Channel pairs are packed {A, B} throughout.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {a_in, b_in};
      sync2_q <= sync1_q;
    end
  end

`ifdef QUAD_STEP_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      filt_q, filt_d;
  logic [1:0][7:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;

  // Debounce length has no meaning in this build; keep it referenced.
  logic unused_db_cfg;
  assign unused_db_cfg = ^8'(DEBOUNCE_CYCLES);
`endif

  // Forward Gray successor: 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
  function automatic logic [1:0] fwd_next(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        prev_q, prev_d;
  logic [1:0]        stable_q, stable_d;
  logic signed [3:0] acc_q, acc_d;
  logic              step_q, step_d;
  logic              err_q, err_d;
  logic              ud_q, ud_d;

  always_comb begin
    state_d  = state_q;
    prev_d   = filt;
    stable_d = stable_q;
    acc_d    = acc_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    ud_d     = ud_q;
    case (state_q)
      ST_INIT: begin
        // Wait for 4 quiet cycles so the level at reset release never counts.
        if (filt != prev_q) begin
          stable_d = '0;
        end else if (stable_q == 2'd3) begin
          state_d  = ST_RUN;
          stable_d = '0;
        end else begin
          stable_d = stable_q + 2'd1;
        end
      end
      default: begin
        if (filt == ~prev_q) begin
          err_d = 1'b1;
          acc_d = '0;
        end else if (filt == fwd_next(prev_q)) begin
          if (acc_q == ACC_MAX) begin
            acc_d  = '0;
            step_d = 1'b1;
            ud_d   = 1'b1;
          end else begin
            acc_d = acc_q + 4'sd1;
          end
        end else if (prev_q == fwd_next(filt)) begin
          if (acc_q == ACC_MIN) begin
            acc_d  = '0;
            step_d = 1'b1;
            ud_d   = 1'b0;
          end else begin
            acc_d = acc_q - 4'sd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      prev_q   <= '0;
      stable_q <= '0;
      acc_q    <= '0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      ud_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      err_q    <= err_d;
      ud_q     <= ud_d;
    end
  end

  assign step = step_q;
  assign err  = err_q;
  assign ud   = ud_q;

endmodule

// File: doc/quad_step_decoder.md
# quad_step_decoder

Front-end stage for the 8-bit up/down counter. It takes the two raw, asynchronous quadrature channels of a rotary encoder, synchronizes them, optionally debounces them and decodes the Gray sequence. It drives the counter's direction input `ud` and produces a one-cycle `step` count-enable qualifier, one per detent. Illegal double transitions are flagged on `err` and never produce a step.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a channel change is accepted. Legal range is 1..255.
- `STEPS_PER_DETENT`, default 4: valid Gray transitions per output step. Legal values are 1, 2 or 4.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `a_in`  in  1  raw encoder channel A, asynchronous to `clk`.
- `b_in`  in  1  raw encoder channel B, asynchronous to `clk`.
- `step`  out  1  one-cycle pulse, one per accepted detent.
- `ud`  out  1  direction of the most recent step: 1 = up, 0 = down. Held between steps.
- `err`  out  1  one-cycle pulse on an illegal transition, i.e. both channels changed in the same cycle.

## Operation
- **Synchronizer:** two flops per channel (`sync1`, `sync2`), both reset to 0.
- **Debounce** (when compiled in):
  - Each channel has a counter, reset to 0, and a filtered bit `filt`, reset to 0.
  - If `sync2 == filt`, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1` at an edge where `sync2 != filt`, `filt <= sync2` and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `filt`.
- **Decoder FSM, states INIT and RUN:**
  - Reset state is INIT. In INIT, `prev <= {filtA, filtB}` every cycle.
  - The FSM moves to RUN after 4 consecutive cycles with `{filtA, filtB} == prev`. Any change restarts that count.
  - In INIT, `step` and `err` stay 0 and the accumulator stays 0.
  - In RUN, each cycle compares `cur = {filtA, filtB}` against `prev`, then sets `prev <= cur`:
    - `cur == prev`: no action.
    - Forward transition (00→10→11→01→00, A leads B): accumulator +1.
    - Reverse transition (00→01→11→10→00): accumulator −1.
    - Both bits differ: `err` pulses for 1 cycle, the accumulator clears to 0, `ud` is unchanged and `step` stays 0.
- **Accumulator:**
  - Signed 4 bits, range −(N−1)..+(N−1), where N = `STEPS_PER_DETENT`. Reset value 0.
  - An update that would reach +N instead sets the accumulator to 0 and registers `step=1`, `ud=1`.
  - An update that would reach −N instead sets the accumulator to 0 and registers `step=1`, `ud=0`.
  - A reversal mid-detent just walks the accumulator back toward 0.
- **Reset values:** `step=0`, `ud=1`, `err=0`, FSM state INIT.
- **Exclusivity:** `step` and `err` are never high in the same cycle.

## Timing
- All outputs are registered; there is no combinational path from `a_in`/`b_in` to any output.
- Let edge n be the first rising edge at which `sync1` captures a new level.
- The filtered value changes at edge n+1 without debounce, or n+1+`DEBOUNCE_CYCLES` with debounce.
- The resulting `step` or `err` is registered one edge later: n+2 without debounce, or n+2+`DEBOUNCE_CYCLES` with debounce.
- `step` and `err` are high for exactly one `clk` cycle.
- `ud` changes only in the cycle `step` rises, and it is valid whenever `step` is high.
- Minimum spacing between accepted transitions:
  - 1 cycle without debounce.
  - `DEBOUNCE_CYCLES`+1 cycles per channel with debounce. Faster edges are filtered, not queued.
- **Reset mid-operation:**
  - Asserting `rst` immediately forces all outputs and state to their reset values, including a `step` or `err` pulse in flight.
  - After deassertion the block re-enters INIT.
  - No step is emitted for the input level present at reset release.

## Configuration
- Macro: `QUAD_STEP_DEBOUNCE_EN`.
- **Defined:** per-channel debounce counters and `filt` registers are instantiated, and `DEBOUNCE_CYCLES` applies.
- **Undefined:** `filt` is wired directly to `sync2`, no debounce logic is generated, and `DEBOUNCE_CYCLES` is ignored. All other behaviour is unchanged.

## Test plan
- **Reset release with inputs at 11:** hold `a_in=b_in=1` through and after reset. Required: `step=0`, `err=0` and `ud=1` for 100 cycles, and the FSM reaches RUN.
- **Forward detents:** debounce enabled, `DEBOUNCE_CYCLES=16`, N=4. Drive 2 full forward cycles (8 transitions, each held 40 cycles). Required: exactly 2 `step` pulses with `ud=1`, each 18 cycles after the 4th transition's capture edge, counted per the Timing definition.
- **Reverse with mid-detent reversal:** N=4. Apply +2 transitions, then −6. Required: exactly 1 `step` with `ud=0`, and a final accumulator value of 0.
- **Glitch rejection:** debounce enabled. Pulse `a_in` high for 10 cycles with `DEBOUNCE_CYCLES=16`. Required: `filtA` never changes, and `step=err=0`.
- **Illegal transition:** debounce compiled out. Switch `a_in`/`b_in` from 00 to 11 on the same edge. Required: `err` high for exactly 1 cycle at edge n+2, no `step`, `ud` unchanged, accumulator 0.
- **Asynchronous reset mid-detent:** N=4, accumulator at +3. Assert `rst` between clock edges. Required: outputs go to reset values immediately; after release plus INIT, a single +1 transition produces no `step`.
